clk_sel_sequencer: RTL



---
 rtl/clk_sel_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/clk_sel_sequencer.sv
// Sequences a 2:1 clock-mux select change: gate the downstream clock off,
// wait, move the select, wait, then re-enable the gate and pulse done.
// Runs on an always-on reference clock behind a valid/ready request port.
module clk_sel_sequencer #(
    parameter int unsigned GateCycles   = 4,
    parameter int unsigned SettleCycles = 4,
    parameter logic        DefaultSel   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_valid_i,
    output logic req_ready_o,
    input  logic req_sel_i,
    output logic clk_sel_o,
    output logic clk_en_o,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned MaxCycles = (GateCycles > SettleCycles) ? GateCycles : SettleCycles;
    localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CntWidth-1:0] GateLoad   = CntWidth'(GateCycles - 1);
    localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SettleCycles - 1);

    // Reject parameter sets that would leave a phase with zero length.
    if (GateCycles < 1 || SettleCycles < 1) begin : g_bad_params
        $error("clk_sel_sequencer: GateCycles and SettleCycles must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SWITCH   = 2'd2,
        GATE_ON  = 2'd3
    } state_e;

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  sel_q;
    logic                  en_q;
    logic                  done_q;
    logic                  target_q;
    logic                  accept_c;

    // GATE_ON is the single done cycle; it already accepts the next request
    // so back-to-back sequences run with no idle gap.
    assign req_ready_o = (state_q == IDLE) || (state_q == GATE_ON);
    assign busy_o      = !req_ready_o;
    assign accept_c    = req_valid_i && req_ready_o;

    assign clk_sel_o = sel_q;
    assign clk_en_o  = en_q;
    assign done_o    = done_q;

    // Sequencer FSM with registered select, enable and done outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= DefaultSel;
            en_q     <= 1'b1;
            done_q   <= 1'b0;
            target_q <= DefaultSel;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, GATE_ON: begin
                    state_q <= IDLE;
                    if (accept_c) begin
                        target_q <= req_sel_i;
                        if (req_sel_i == sel_q) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= GATE_OFF;
                            en_q    <= 1'b0;
                            cnt_q   <= GateLoad;
                        end
                    end
                end
                GATE_OFF: begin
                    if (cnt_q == '0) begin
                        state_q <= SWITCH;
                        sel_q   <= target_q;
                        cnt_q   <= SettleLoad;
                    end else begin
                        cnt_q <= cnt_q - CntWidth'(1);
                    end
                end
                SWITCH: begin
                    if (cnt_q == '0) begin
                        state_q <= GATE_ON;
                        en_q    <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntWidth'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Requester must hold the select stable while a request is stalled.
    a_req_sel_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=> $stable(req_sel_i));

endmodule
